// File: rtl/sdp_relu_pipe_if.sv
// ---------------------------------------------------------------------------
// sdp_relu_pipe_if
// Bundles the beat handshakes, per-beat configuration and statistics counter
// of the SDP activation stage into one interface.
//   in_pd/in_vld/in_rdy     : upstream beat channel (LANES*16 bits per beat)
//   out_pd/out_vld/out_rdy  : downstream beat channel
//   cfg_relu_mode           : 0 bypass, 1 relu, 2 clipped relu, 3 leaky relu
//   cfg_precision           : 0 int8, 1 int16, 2 fp16, 3 int16
//   cfg_clip_max            : clip ceiling (signed, int8 uses [7:0])
//   cfg_leak_shift          : leaky slope 2^-shift
//   cnt_clr/zero_cnt        : clear and value of the zeroed-element counter
// master drives the stage (upstream/downstream side), slave is the stage.
// ---------------------------------------------------------------------------
interface sdp_relu_pipe_if #(
  parameter int LANES = 32,
  parameter int CNT_W = 32
);
  logic [LANES*16-1:0] in_pd;
  logic                in_vld;
  logic                in_rdy;
  logic [LANES*16-1:0] out_pd;
  logic                out_vld;
  logic                out_rdy;
  logic [1:0]          cfg_relu_mode;
  logic [1:0]          cfg_precision;
  logic [15:0]         cfg_clip_max;
  logic [3:0]          cfg_leak_shift;
  logic                cnt_clr;
  logic [CNT_W-1:0]    zero_cnt;

  modport master (
    output in_pd, in_vld, out_rdy,
    output cfg_relu_mode, cfg_precision, cfg_clip_max, cfg_leak_shift, cnt_clr,
    input  in_rdy, out_pd, out_vld, zero_cnt
  );

  modport slave (
    input  in_pd, in_vld, out_rdy,
    input  cfg_relu_mode, cfg_precision, cfg_clip_max, cfg_leak_shift, cnt_clr,
    output in_rdy, out_pd, out_vld, zero_cnt
  );
endinterface

// File: rtl/sdp_relu_pipe.sv
// ---------------------------------------------------------------------------
// sdp_relu_pipe
// Pipelined SDP activation stage: bypass / relu / clipped relu / leaky relu
// over LANES packed 16-bit lanes per beat, in int8 (two elements per lane),
// int16 or fp16. Configuration is captured with each accepted beat.
// Two register stages: S1 holds the computed beat, S2 drives the output.
// A saturating counter accumulates elements forced to zero on each output
// transfer.
// Ports:
//   nvdla_core_clk : core clock
//   nvdla_core_rst : asynchronous reset, active high
//   bus            : sdp_relu_pipe_if slave (beats, config, counter)
// ---------------------------------------------------------------------------
module sdp_relu_pipe #(
  parameter int LANES = 32,
  parameter int CNT_W = 32
) (
  input logic            nvdla_core_clk,
  input logic            nvdla_core_rst,
  sdp_relu_pipe_if.slave bus
);

  localparam int W    = LANES * 16;
  localparam int ZC_W = $clog2(2 * LANES + 1);
  localparam int SW   = CNT_W + 1;

  // Signed 8-bit activation; leaky shifts of 8 or more saturate to -1 because
  // the arithmetic shift replicates the sign bit.
  function automatic logic [7:0] act8(input logic [7:0] x, input logic [1:0] mode,
                                      input logic [7:0] clip, input logic [3:0] shift);
    logic signed [7:0] sx;
    logic signed [7:0] sc;
    logic signed [7:0] r;
    sx = x;
    sc = clip;
    if (sc < 0) sc = '0;
    r = sx;
    if (mode != 2'd0 && sx < 0) begin
      if (mode == 2'd3) r = sx >>> shift;
      else              r = '0;
    end else if (mode == 2'd2 && sx > sc) begin
      r = sc;
    end
    return r;
  endfunction

  // Signed 16-bit activation, same rules as the 8-bit version.
  function automatic logic [15:0] act16(input logic [15:0] x, input logic [1:0] mode,
                                        input logic [15:0] clip, input logic [3:0] shift);
    logic signed [15:0] sx;
    logic signed [15:0] sc;
    logic signed [15:0] r;
    sx = x;
    sc = clip;
    if (sc < 0) sc = '0;
    r = sx;
    if (mode != 2'd0 && sx < 0) begin
      if (mode == 2'd3) r = sx >>> shift;
      else              r = '0;
    end else if (mode == 2'd2 && sx > sc) begin
      r = sc;
    end
    return r;
  endfunction

  logic            rdyEn_q;
  logic            s1Vld_q, s1Vld_d;
  logic            s2Vld_q, s2Vld_d;
  logic [W-1:0]    s1Pd_q, s1Pd_d;
  logic [W-1:0]    s2Pd_q, s2Pd_d;
  logic [ZC_W-1:0] s1Zc_q, s1Zc_d;
  logic [ZC_W-1:0] s2Zc_q, s2Zc_d;
  logic [CNT_W-1:0] zeroCnt_q, zeroCnt_d;
  logic [W-1:0]    compPd;
  logic [ZC_W-1:0] compZc;
  logic [15:0]     lane, res;
  logic [7:0]      lo, hi;
  logic [SW-1:0]   sum;
  logic            accept, s2Free, outXfer;

  // Ready comes up one cycle after reset release; afterwards a beat can enter
  // whenever either stage has room or the output is draining this cycle.
  assign bus.in_rdy = rdyEn_q & (!s1Vld_q | !s2Vld_q | bus.out_rdy);
  assign accept     = bus.in_vld & bus.in_rdy;
  assign s2Free     = !s2Vld_q | bus.out_rdy;
  assign outXfer    = s2Vld_q & bus.out_rdy;

  assign bus.out_pd   = s2Pd_q;
  assign bus.out_vld  = s2Vld_q;
  assign bus.zero_cnt = zeroCnt_q;

  // Element datapath working straight off the input beat and its config, so
  // the result (and its count of newly zeroed elements) lands in S1 on accept.
  // fp16 negatives (including -0, -inf, negative NaN) go to +0 in every
  // non-bypass mode; -0 is not counted since its magnitude is already zero.
  always_comb begin
    compPd = '0;
    compZc = '0;
    lane   = '0;
    res    = '0;
    lo     = '0;
    hi     = '0;
    for (int i = 0; i < LANES; i++) begin
      lane = bus.in_pd[16*i +: 16];
      if (bus.cfg_precision == 2'd0) begin
        lo  = act8(lane[7:0],  bus.cfg_relu_mode, bus.cfg_clip_max[7:0], bus.cfg_leak_shift);
        hi  = act8(lane[15:8], bus.cfg_relu_mode, bus.cfg_clip_max[7:0], bus.cfg_leak_shift);
        res = {hi, lo};
        if (lane[7:0]  != 8'd0 && lo == 8'd0) compZc = compZc + ZC_W'(1);
        if (lane[15:8] != 8'd0 && hi == 8'd0) compZc = compZc + ZC_W'(1);
      end else if (bus.cfg_precision == 2'd2) begin
        res = (bus.cfg_relu_mode != 2'd0 && lane[15]) ? 16'h0000 : lane;
        if (lane[14:0] != 15'd0 && res == 16'h0000) compZc = compZc + ZC_W'(1);
      end else begin
        res = act16(lane, bus.cfg_relu_mode, bus.cfg_clip_max, bus.cfg_leak_shift);
        if (lane != 16'd0 && res == 16'd0) compZc = compZc + ZC_W'(1);
      end
      compPd[16*i +: 16] = res;
    end
  end

  // Stage advance: S1 loads on accept and empties once S2 can take it; S2
  // reloads only when it is empty or being drained, which keeps the output
  // frozen under backpressure.
  always_comb begin
    s1Vld_d = s1Vld_q;
    s1Pd_d  = s1Pd_q;
    s1Zc_d  = s1Zc_q;
    s2Vld_d = s2Vld_q;
    s2Pd_d  = s2Pd_q;
    s2Zc_d  = s2Zc_q;
    if (s2Free) begin
      s2Vld_d = s1Vld_q;
      if (s1Vld_q) begin
        s2Pd_d = s1Pd_q;
        s2Zc_d = s1Zc_q;
      end
    end
    if (accept) begin
      s1Vld_d = 1'b1;
      s1Pd_d  = compPd;
      s1Zc_d  = compZc;
    end else if (s1Vld_q && s2Free) begin
      s1Vld_d = 1'b0;
    end
  end

  // Saturating statistics counter; a clear in the same cycle as a transfer
  // discards that beat's contribution.
  always_comb begin
    sum       = {1'b0, zeroCnt_q} + SW'(s2Zc_q);
    zeroCnt_d = zeroCnt_q;
    if (bus.cnt_clr)   zeroCnt_d = '0;
    else if (outXfer)  zeroCnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end

  // All state registers, cleared asynchronously so in-flight beats vanish.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      rdyEn_q   <= 1'b0;
      s1Vld_q   <= 1'b0;
      s1Pd_q    <= '0;
      s1Zc_q    <= '0;
      s2Vld_q   <= 1'b0;
      s2Pd_q    <= '0;
      s2Zc_q    <= '0;
      zeroCnt_q <= '0;
    end else begin
      rdyEn_q   <= 1'b1;
      s1Vld_q   <= s1Vld_d;
      s1Pd_q    <= s1Pd_d;
      s1Zc_q    <= s1Zc_d;
      s2Vld_q   <= s2Vld_d;
      s2Pd_q    <= s2Pd_d;
      s2Zc_q    <= s2Zc_d;
      zeroCnt_q <= zeroCnt_d;
    end
  end

endmodule
